// File: rtl/kanagawa_delay_tolerant_fifo.sv
// Show-ahead storage FIFO behind the pre-FIFO delay stage, with almost-full slack for in-flight writes.
// Optional high-water mark output under KANAGAWA_DELAY_TOLERANT_FIFO_WATERMARK_EN.
module kanagawa_delay_tolerant_fifo #(
   parameter int WIDTH             = 16,
   parameter int DEPTH             = 32,
   parameter int ALMOST_FULL_SLACK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wrreq_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             almost_full_out,
   input  logic             rdreq_in,
   output logic [WIDTH-1:0] data_out,
   output logic             empty_out,
   output logic             overflow_out
`ifdef KANAGAWA_DELAY_TOLERANT_FIFO_WATERMARK_EN
  ,output logic [$clog2(DEPTH):0] high_watermark_out
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             empty_q, empty_d;
   logic             af_q, af_d;
   logic             ovf_q, ovf_d;
   logic             pop, accept;

   always_comb begin
      pop      = rdreq_in & ~empty_q;
      // a pop in the same cycle frees the slot a full-FIFO write needs
      accept   = wrreq_in & ((count_q < CW'(DEPTH)) | pop);
      count_d  = count_q + CW'(accept) - CW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(accept);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      empty_d  = (count_d == '0);
      af_d     = (count_d >= CW'(DEPTH - ALMOST_FULL_SLACK));
      ovf_d    = ovf_q | (wrreq_in & ~accept);
      mem_d    = mem_q;
      if (accept) mem_d[wr_ptr_q] = data_in;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         af_q     <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ovf_q    <= ovf_d;
      end
   end

   assign data_out        = empty_q ? '0 : mem_q[rd_ptr_q];
   assign empty_out       = empty_q;
   assign almost_full_out = af_q;
   assign overflow_out    = ovf_q;

`ifdef KANAGAWA_DELAY_TOLERANT_FIFO_WATERMARK_EN
   logic [CW-1:0] hw_q, hw_d;

   always_comb begin
      hw_d = (count_q > hw_q) ? count_q : hw_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) hw_q <= '0;
      else        hw_q <= hw_d;
   end

   assign high_watermark_out = hw_q;
`endif

endmodule

// File: tb/tb_kanagawa_delay_tolerant_fifo.sv
// Randomized self-checking bench for kanagawa_delay_tolerant_fifo against a queue model.
// Watermark checks compiled in with KANAGAWA_DELAY_TOLERANT_FIFO_WATERMARK_EN.
module tb_kanagawa_delay_tolerant_fifo;

   localparam int W     = 16;
   localparam int DEPTH = 32;
   localparam int SLACK = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         wrreq_in = 1'b0;
   logic [W-1:0] data_in = '0;
   logic         rdreq_in = 1'b0;
   logic         almost_full_out;
   logic [W-1:0] data_out;
   logic         empty_out;
   logic         overflow_out;
`ifdef KANAGAWA_DELAY_TOLERANT_FIFO_WATERMARK_EN
   logic [5:0]   high_watermark_out;
`endif

   kanagawa_delay_tolerant_fifo #(
      .WIDTH(W), .DEPTH(DEPTH), .ALMOST_FULL_SLACK(SLACK)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wrreq_in(wrreq_in),
      .data_in(data_in),
      .almost_full_out(almost_full_out),
      .rdreq_in(rdreq_in),
      .data_out(data_out),
      .empty_out(empty_out),
      .overflow_out(overflow_out)
`ifdef KANAGAWA_DELAY_TOLERANT_FIFO_WATERMARK_EN
     ,.high_watermark_out(high_watermark_out)
`endif
   );

   always #5 clk = ~clk;

   logic [W-1:0] q[$];
   bit           m_ovf;
   int           m_max;
   int           drops;
   int           tests_run = 0;
   int           fails = 0;

   // drive one cycle of inputs, then advance the reference model
   task automatic cycle(input bit wr, input logic [W-1:0] d, input bit rd);
      bit pop, acc;
      wrreq_in = wr;
      data_in  = d;
      rdreq_in = rd;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         q.delete();
         m_ovf = 0;
         m_max = 0;
      end else begin
         pop = rd && (q.size() > 0);
         acc = wr && ((q.size() < DEPTH) || pop);
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(d);
         if (wr && !acc) begin
            m_ovf = 1;
            drops++;
         end
         if (q.size() > m_max) m_max = q.size();
      end
      wrreq_in = 1'b0;
      rdreq_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cycle(0, '0, 0);
      tests_run++;
      if (empty_out !== 1'b1 || almost_full_out !== 1'b1 || overflow_out !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: empty=%b af=%b ovf=%b required 1 1 0",
                  empty_out, almost_full_out, overflow_out);
      end
      rst_n = 1'b1;
      cycle(0, '0, 0);
      tests_run++;
      if (almost_full_out !== 1'b0 || empty_out !== 1'b1) begin
         fails++;
         $display("FAIL reset_release: af=%b empty=%b required 0 1",
                  almost_full_out, empty_out);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1, W'(i), 0);
         tests_run++;
         if (empty_out !== 1'b0 || overflow_out !== 1'b0 ||
             almost_full_out !== (q.size() >= DEPTH - SLACK) || data_out !== q[0]) begin
            fails++;
            $display("FAIL fill[%0d]: empty=%b ovf=%b af=%b head=%h required 0 0 %b %h",
                     i, empty_out, overflow_out, almost_full_out, data_out,
                     (q.size() >= DEPTH - SLACK), q[0]);
         end
      end
   endtask

   task automatic test_overflow();
      cycle(1, 16'hBEEF, 0);
      tests_run++;
      if (overflow_out !== m_ovf || m_ovf !== 1'b1) begin
         fails++;
         $display("FAIL overflow_set: ovf=%b required 1", overflow_out);
      end
      cycle(0, '0, 0);
      tests_run++;
      if (overflow_out !== 1'b1) begin
         fails++;
         $display("FAIL overflow_sticky: ovf=%b required 1", overflow_out);
      end
      for (int i = 0; i < DEPTH; i++) begin
         tests_run++;
         if (empty_out !== 1'b0 || data_out !== W'(i)) begin
            fails++;
            $display("FAIL drain[%0d]: empty=%b data=%h required 0 %h",
                     i, empty_out, data_out, W'(i));
         end
         cycle(0, '0, 1);
      end
      tests_run++;
      if (empty_out !== 1'b1 || overflow_out !== 1'b1) begin
         fails++;
         $display("FAIL drain_end: empty=%b ovf=%b required 1 1", empty_out, overflow_out);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < DEPTH; i++) cycle(1, W'($urandom), 0);
      for (int i = 0; i < 40; i++) begin
         tests_run++;
         if (data_out !== q[0]) begin
            fails++;
            $display("FAIL stream_head[%0d]: data=%h required %h", i, data_out, q[0]);
         end
         cycle(1, W'($urandom), 1);
         tests_run++;
         if (empty_out !== 1'b0 || almost_full_out !== 1'b1 || overflow_out !== 1'b0 ||
             q.size() != DEPTH) begin
            fails++;
            $display("FAIL stream_state[%0d]: empty=%b af=%b ovf=%b required 0 1 0",
                     i, empty_out, almost_full_out, overflow_out);
         end
      end
      while (q.size() > 0) begin
         tests_run++;
         if (data_out !== q[0]) begin
            fails++;
            $display("FAIL stream_drain: data=%h required %h", data_out, q[0]);
         end
         cycle(0, '0, 1);
      end
      tests_run++;
      if (empty_out !== 1'b1) begin
         fails++;
         $display("FAIL stream_empty: empty=%b required 1", empty_out);
      end
   endtask

   task automatic test_empty_simul();
      cycle(1, 16'h1234, 1);
      tests_run++;
      if (empty_out !== 1'b0 || data_out !== 16'h1234) begin
         fails++;
         $display("FAIL empty_simul: empty=%b data=%h required 0 1234", empty_out, data_out);
      end
      cycle(0, '0, 1);
      tests_run++;
      if (empty_out !== 1'b1) begin
         fails++;
         $display("FAIL empty_simul_pop: empty=%b required 1", empty_out);
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 17; i++) cycle(1, W'($urandom), 0);
      rst_n = 1'b0;
      cycle(1, W'($urandom), 0);
      tests_run++;
      if (empty_out !== 1'b1 || almost_full_out !== 1'b1 || overflow_out !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: empty=%b af=%b ovf=%b required 1 1 0",
                  empty_out, almost_full_out, overflow_out);
      end
      rst_n = 1'b1;
      cycle(0, '0, 0);
      tests_run++;
      if (almost_full_out !== 1'b0 || empty_out !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset_release: af=%b empty=%b required 0 1",
                  almost_full_out, empty_out);
      end
   endtask

   // upstream with 1-cycle feed-forward and 2-cycle almost_full feedback
   task automatic test_delay_stage();
      bit           af_h1, af_h2, ff_wr, up_wr;
      logic [W-1:0] ff_data, seq;
      int           bad;
      af_h1   = almost_full_out;
      af_h2   = almost_full_out;
      ff_wr   = 0;
      ff_data = '0;
      seq     = '0;
      bad     = 0;
      drops   = 0;
      for (int i = 0; i < 1000; i++) begin
         up_wr = !af_h2;
         af_h2 = af_h1;
         af_h1 = almost_full_out;
         cycle(ff_wr, ff_data, ($urandom_range(0, 1) == 1));
         ff_wr   = up_wr;
         ff_data = seq;
         if (up_wr) seq = seq + 1'b1;
         tests_run++;
         if (empty_out !== (q.size() == 0) ||
             almost_full_out !== (q.size() >= DEPTH - SLACK) ||
             (q.size() > 0 && data_out !== q[0])) begin
            fails++;
            bad++;
            if (bad < 5)
               $display("FAIL delay_stage[%0d]: empty=%b af=%b data=%h model_count=%0d",
                        i, empty_out, almost_full_out, data_out, q.size());
         end
      end
      tests_run++;
      if (drops != 0 || overflow_out !== 1'b0) begin
         fails++;
         $display("FAIL delay_drops: drops=%0d ovf=%b required 0 0", drops, overflow_out);
      end
`ifdef KANAGAWA_DELAY_TOLERANT_FIFO_WATERMARK_EN
      cycle(0, '0, 0);
      cycle(0, '0, 0);
      tests_run++;
      if (int'(high_watermark_out) != m_max || high_watermark_out > 6'd32) begin
         fails++;
         $display("FAIL watermark: got %0d required %0d", high_watermark_out, m_max);
      end
`endif
   endtask

   initial begin
      m_ovf = 0;
      m_max = 0;
      drops = 0;
      test_reset();
      test_fill();
      test_overflow();
      test_reset();
      test_back_to_back();
      test_empty_simul();
      test_mid_reset();
      test_delay_stage();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
